aq_cjpeg_fdct_calc: RTL and testbench



---
 rtl/aq_cjpeg_fdct_calc.sv | 204 ++++++++++++++++++++
 tb/tb_aq_cjpeg_fdct_calc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_cjpeg_fdct_calc.sv
// Forward 8-point 1-D DCT (x4096 fixed point, no rounding): 8 pages per block, 4 mirrored reads per page.
// Define AQ_CJPEG_FDCT_LEVEL_SHIFT_EN to treat DataInA/B[7:0] as unsigned pixels with a -128 level shift.
module aq_cjpeg_fdct_calc (
    input  logic        clk,
    input  logic        rst,
    input  logic        DataInEnable,
    output logic        DataInRead,
    output logic [4:0]  DataInAddress,
    input  logic [15:0] DataInA,
    input  logic [15:0] DataInB,
    output logic        DataOutEnable,
    output logic [2:0]  DataOutPage,
    output logic [1:0]  DataOutCount,
    output logic [31:0] Data0Out,
    output logic [31:0] Data1Out
);

    localparam logic [12:0] C1 = 13'd4017;
    localparam logic [12:0] C2 = 13'd3784;
    localparam logic [12:0] C3 = 13'd3406;
    localparam logic [12:0] C4 = 13'd2896;
    localparam logic [12:0] C5 = 13'd2276;
    localparam logic [12:0] C6 = 13'd1567;
    localparam logic [12:0] C7 = 13'd799;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_n;
    logic [2:0]  page_q, page_n;
    logic [2:0]  cnt_q, cnt_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            page_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            page_q  <= page_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        page_n  = page_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (DataInEnable) begin
                    state_n = RUN;
                    page_n  = '0;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                if (cnt_q == 3'd6) begin
                    cnt_n = '0;
                    if (page_q == 3'd7) begin
                        state_n = IDLE;
                        page_n  = '0;
                    end else begin
                        page_n = page_q + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_q + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign DataInRead    = (state_q == RUN) && (cnt_q < 3'd4);
    assign DataInAddress = {page_q, cnt_q[1:0]};

    // ph[i] marks cycle t0+i of a page; independent of the sequencer so the last page drains after IDLE
    logic        start;
    logic [10:1] ph;
    logic [2:0]  pg_hold;
    assign start = DataInRead && (cnt_q == 3'd0);

    logic signed [15:0] xa, xb;
`ifdef AQ_CJPEG_FDCT_LEVEL_SHIFT_EN
    assign xa = {8'h00, DataInA[7:0]} - 16'd128;
    assign xb = {8'h00, DataInB[7:0]} - 16'd128;
`else
    assign xa = DataInA;
    assign xb = DataInB;
`endif

    logic signed [16:0] s_in, d_in;
    logic signed [17:0] dx, dn;
    assign s_in = {xa[15], xa} + {xb[15], xb};
    assign d_in = {xa[15], xa} - {xb[15], xb};
    assign dx   = {d_in[16], d_in};
    assign dn   = -dx;

    logic signed [16:0] s_q [4];
    logic signed [17:0] a0, a1, a2, a3;
    assign a0 = {s_q[0][16], s_q[0]} + {s_q[3][16], s_q[3]};
    assign a1 = {s_q[1][16], s_q[1]} + {s_q[2][16], s_q[2]};
    assign a2 = {s_q[1][16], s_q[1]} - {s_q[2][16], s_q[2]};
    assign a3 = {s_q[0][16], s_q[0]} - {s_q[3][16], s_q[3]};

    logic               odd_act;
    logic [1:0]         kidx;
    logic signed [17:0] op  [4];
    logic [12:0]        cst [4];
    logic signed [31:0] prod [4];
    assign odd_act = |ph[4:1];
    assign kidx    = ph[2] ? 2'd1 : ph[3] ? 2'd2 : ph[4] ? 2'd3 : 2'd0;

    // Odd outputs accumulate one d_k per cycle (signs folded into the operand); even part uses ph5/ph6
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            op[i]  = '0;
            cst[i] = '0;
        end
        if (odd_act) begin
            unique case (kidx)
                2'd0: begin op = '{dx, dx, dx, dx}; cst = '{C1, C3, C5, C7}; end
                2'd1: begin op = '{dx, dn, dn, dn}; cst = '{C3, C7, C1, C5}; end
                2'd2: begin op = '{dx, dn, dx, dx}; cst = '{C5, C1, C7, C3}; end
                default: begin op = '{dx, dn, dx, dn}; cst = '{C7, C5, C3, C1}; end
            endcase
        end else if (ph[5]) begin
            op  = '{a0, a1, a3, a2};
            cst = '{C4, C4, C2, C6};
        end else if (ph[6]) begin
            op[0]  = a3;
            cst[0] = C6;
            op[1]  = a2;
            cst[1] = C2;
        end
        for (int unsigned i = 0; i < 4; i++)
            prod[i] = $signed({{14{op[i][17]}}, op[i]}) * $signed({19'd0, cst[i]});
    end

    logic signed [31:0] acc [4];
    logic signed [31:0] oh  [4];
    logic signed [31:0] x0, x2, x4, x6;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph            <= '0;
            pg_hold       <= '0;
            x0            <= '0;
            x2            <= '0;
            x4            <= '0;
            x6            <= '0;
            DataOutEnable <= 1'b0;
            DataOutPage   <= '0;
            DataOutCount  <= '0;
            Data0Out      <= '0;
            Data1Out      <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                s_q[i] <= '0;
                acc[i] <= '0;
                oh[i]  <= '0;
            end
        end else begin
            ph <= {ph[9:1], start};
            if (start)
                pg_hold <= page_q;
            if (odd_act)
                s_q[kidx] <= s_in;
            for (int unsigned i = 0; i < 4; i++) begin
                if (ph[1])
                    acc[i] <= prod[i];
                else if (|ph[4:2])
                    acc[i] <= acc[i] + prod[i];
                if (ph[5])
                    oh[i] <= acc[i];
            end
            if (ph[5]) begin
                x0 <= prod[0] + prod[1];
                x4 <= prod[0] - prod[1];
                x2 <= prod[2] + prod[3];
            end
            if (ph[6])
                x6 <= prod[0] - prod[1];
            DataOutEnable <= |ph[10:7];
            if (ph[7]) begin
                DataOutPage  <= pg_hold;
                DataOutCount <= 2'd0;
                Data0Out     <= x0;
                Data1Out     <= x4;
            end else if (ph[8]) begin
                DataOutCount <= 2'd1;
                Data0Out     <= x2;
                Data1Out     <= x6;
            end else if (ph[9]) begin
                DataOutCount <= 2'd2;
                Data0Out     <= oh[0];
                Data1Out     <= oh[3];
            end else if (ph[10]) begin
                DataOutCount <= 2'd3;
                Data0Out     <= oh[1];
                Data1Out     <= oh[2];
            end
        end
    end

endmodule

// File: tb/tb_aq_cjpeg_fdct_calc.sv
// Self-checking bench for aq_cjpeg_fdct_calc: cosine-matrix reference model, timing and reset checks.
module tb_aq_cjpeg_fdct_calc;

    logic        clk;
    logic        rst;
    logic        DataInEnable;
    logic        DataInRead;
    logic [4:0]  DataInAddress;
    logic [15:0] DataInA;
    logic [15:0] DataInB;
    logic        DataOutEnable;
    logic [2:0]  DataOutPage;
    logic [1:0]  DataOutCount;
    logic [31:0] Data0Out;
    logic [31:0] Data1Out;

    aq_cjpeg_fdct_calc dut (
        .clk(clk), .rst(rst), .DataInEnable(DataInEnable),
        .DataInRead(DataInRead), .DataInAddress(DataInAddress),
        .DataInA(DataInA), .DataInB(DataInB),
        .DataOutEnable(DataOutEnable), .DataOutPage(DataOutPage), .DataOutCount(DataOutCount),
        .Data0Out(Data0Out), .Data1Out(Data1Out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int fails  = 0;

    int samp [4][64];
    int rdcnt   = 0;
    int rd_base = 0;

    int cyc  = 0;
    int ocnt = 0;
    int tcnt = 0;
    int o_cyc [1024];
    int o_pg  [1024];
    int o_ct  [1024];
    int o_d0  [1024];
    int o_d1  [1024];
    int t_cyc [1024];

    int cos_tab [9] = '{4096, 4017, 3784, 3406, 2896, 2276, 1567, 799, 0};
    int u_first [4] = '{0, 2, 1, 3};
    int u_second[4] = '{4, 6, 7, 5};

    // Responder: one cycle after a read strobe, present the mirrored pair for that address
    initial begin
        logic       r;
        logic [4:0] ad;
        int         blk, p, c;
        DataInA = '0;
        DataInB = '0;
        forever begin
            @(negedge clk);
            r  = DataInRead;
            ad = DataInAddress;
            @(posedge clk);
            #1;
            if (r) begin
                blk = ((rdcnt - rd_base) / 32) % 4;
                p   = int'(ad[4:2]);
                c   = int'(ad[1:0]);
                DataInA = 16'(samp[blk][p*8 + c]);
                DataInB = 16'(samp[blk][p*8 + 7 - c]);
                rdcnt++;
            end else begin
                DataInA = 16'($urandom);
                DataInB = 16'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (DataInRead && DataInAddress[1:0] == 2'd0) begin
                t_cyc[tcnt % 1024] = cyc;
                tcnt++;
            end
            if (DataOutEnable) begin
                o_cyc[ocnt % 1024] = cyc;
                o_pg[ocnt % 1024]  = int'(DataOutPage);
                o_ct[ocnt % 1024]  = int'(DataOutCount);
                o_d0[ocnt % 1024]  = int'(signed'(Data0Out));
                o_d1[ocnt % 1024]  = int'(signed'(Data1Out));
                ocnt++;
            end
        end
    end

    function automatic int sample_val(input int raw);
        logic signed [15:0] t;
`ifdef AQ_CJPEG_FDCT_LEVEL_SHIFT_EN
        return (raw & 255) - 128;
`else
        t = 16'(raw);
        return int'(t);
`endif
    endfunction

    // X_u = sum_n x[n] * round(4096*cos((2n+1)u*pi/16)), with C4 used for u=0
    function automatic int coef(input int blk, input int p, input int u);
        longint acc;
        int     m, k, sg;
        acc = 0;
        for (int n = 0; n < 8; n++) begin
            if (u == 0) begin
                k  = 4;
                sg = 1;
            end else begin
                m  = ((2*n + 1) * u) % 32;
                if (m > 16) m = 32 - m;
                if (m > 8) begin
                    k  = 16 - m;
                    sg = -1;
                end else begin
                    k  = m;
                    sg = 1;
                end
            end
            acc += longint'(sample_val(samp[blk][p*8 + n])) * longint'(sg * cos_tab[k]);
        end
        return int'(acc);
    endfunction

    task automatic start_block();
        @(posedge clk);
        #1 DataInEnable = 1'b1;
        @(posedge clk);
        #1 DataInEnable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        DataInEnable = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (DataInRead !== 1'b0) begin fails++; $display("FAIL reset_rd got %b want 0", DataInRead); end
        if (DataInAddress !== 5'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", DataInAddress); end
        if (DataOutEnable !== 1'b0) begin fails++; $display("FAIL reset_oe got %b want 0", DataOutEnable); end
        if (DataOutPage !== 3'd0) begin fails++; $display("FAIL reset_page got %0d want 0", DataOutPage); end
        if (DataOutCount !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", DataOutCount); end
        if (Data0Out !== 32'd0) begin fails++; $display("FAIL reset_d0 got %0d want 0", Data0Out); end
        if (Data1Out !== 32'd0) begin fails++; $display("FAIL reset_d1 got %0d want 0", Data1Out); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_patterns();
        int ob, tb0, p, c, e0, e1, w;
        for (int pat = 0; pat < 7; pat++) begin
            for (int i = 0; i < 64; i++) begin
                case (pat)
                    0: samp[0][i] = 100;
                    1: samp[0][i] = (i % 8 == 0) ? 1 : 0;
                    2: samp[0][i] = (i % 8 == 0) ? -32768 : ((i % 8 == 7) ? 32767 : 0);
                    3: samp[0][i] = 128;
                    4: samp[0][i] = 255;
                    default: samp[0][i] = int'($urandom_range(0, 65535));
                endcase
            end
            rd_base = rdcnt;
            ob  = ocnt;
            tb0 = tcnt;
            start_block();
            for (int i = 0; i < 300 && ocnt < ob + 32; i++) @(negedge clk);
            repeat (20) @(negedge clk);
            checks++;
            if (ocnt - ob != 32) begin
                fails++;
                $display("FAIL pat%0d_pair_count got %0d want 32", pat, ocnt - ob);
            end else begin
                for (int j = 0; j < 32; j++) begin
                    w  = (ob + j) % 1024;
                    p  = j / 4;
                    c  = j % 4;
                    e0 = coef(0, p, u_first[c]);
                    e1 = coef(0, p, u_second[c]);
                    checks += 5;
                    if (o_pg[w] != p) begin fails++; $display("FAIL pat%0d_page j=%0d got %0d want %0d", pat, j, o_pg[w], p); end
                    if (o_ct[w] != c) begin fails++; $display("FAIL pat%0d_count j=%0d got %0d want %0d", pat, j, o_ct[w], c); end
                    if (o_cyc[w] != t_cyc[(tb0 + p) % 1024] + 8 + c) begin
                        fails++;
                        $display("FAIL pat%0d_latency j=%0d got %0d want %0d", pat, j, o_cyc[w] - t_cyc[(tb0 + p) % 1024], 8 + c);
                    end
                    if (o_d0[w] != e0) begin fails++; $display("FAIL pat%0d_d0 p=%0d c=%0d got %0d want %0d", pat, p, c, o_d0[w], e0); end
                    if (o_d1[w] != e1) begin fails++; $display("FAIL pat%0d_d1 p=%0d c=%0d got %0d want %0d", pat, p, c, o_d1[w], e1); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ob, tb0, b, p, c, e0, e1, w;
        for (int bb = 0; bb < 2; bb++)
            for (int i = 0; i < 64; i++) samp[bb][i] = int'($urandom_range(0, 65535));
        rd_base = rdcnt;
        ob  = ocnt;
        tb0 = tcnt;
        @(posedge clk);
        #1 DataInEnable = 1'b1;
        for (int i = 0; i < 200 && tcnt < tb0 + 9; i++) @(negedge clk);
        @(posedge clk);
        #1 DataInEnable = 1'b0;
        for (int i = 0; i < 400 && ocnt < ob + 64; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks += 2;
        if (tcnt - tb0 < 16 || t_cyc[(tb0 + 8) % 1024] - t_cyc[tb0 % 1024] != 57) begin
            fails++;
            $display("FAIL b2b_block_period got %0d want 57", t_cyc[(tb0 + 8) % 1024] - t_cyc[tb0 % 1024]);
        end
        if (ocnt - ob != 64) begin
            fails++;
            $display("FAIL b2b_pair_count got %0d want 64", ocnt - ob);
        end else begin
            for (int j = 0; j < 64; j++) begin
                w  = (ob + j) % 1024;
                b  = j / 32;
                p  = (j / 4) % 8;
                c  = j % 4;
                e0 = coef(b, p, u_first[c]);
                e1 = coef(b, p, u_second[c]);
                checks += 4;
                if (o_pg[w] != p || o_ct[w] != c) begin
                    fails++;
                    $display("FAIL b2b_tag j=%0d got p%0d c%0d want p%0d c%0d", j, o_pg[w], o_ct[w], p, c);
                end
                if (o_cyc[w] != t_cyc[(tb0 + b*8 + p) % 1024] + 8 + c) begin
                    fails++;
                    $display("FAIL b2b_latency j=%0d got %0d want %0d", j, o_cyc[w] - t_cyc[(tb0 + b*8 + p) % 1024], 8 + c);
                end
                if (o_d0[w] != e0) begin fails++; $display("FAIL b2b_d0 b=%0d p=%0d c=%0d got %0d want %0d", b, p, c, o_d0[w], e0); end
                if (o_d1[w] != e1) begin fails++; $display("FAIL b2b_d1 b=%0d p=%0d c=%0d got %0d want %0d", b, p, c, o_d1[w], e1); end
            end
        end
    endtask

    task automatic test_reset_midblock();
        int ob, p, c, e0, e1, w;
        bit hit;
        for (int i = 0; i < 64; i++) samp[0][i] = int'($urandom_range(0, 65535));
        rd_base = rdcnt;
        start_block();
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = DataInRead && (DataInAddress[4:2] == 3'd3);
        end
        checks++;
        if (!hit) begin fails++; $display("FAIL midrst_reach_page3 got 0 want 1"); end
        #1 rst = 1'b0;
        #1;
        checks += 5;
        if (DataInRead !== 1'b0) begin fails++; $display("FAIL midrst_rd got %b want 0", DataInRead); end
        if (DataInAddress !== 5'd0) begin fails++; $display("FAIL midrst_addr got %0d want 0", DataInAddress); end
        if (DataOutEnable !== 1'b0) begin fails++; $display("FAIL midrst_oe got %b want 0", DataOutEnable); end
        if (Data0Out !== 32'd0 || Data1Out !== 32'd0) begin fails++; $display("FAIL midrst_data got %0d/%0d want 0/0", Data0Out, Data1Out); end
        if (DataOutPage !== 3'd0 || DataOutCount !== 2'd0) begin fails++; $display("FAIL midrst_tag got %0d/%0d want 0/0", DataOutPage, DataOutCount); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ob = ocnt;
        repeat (40) @(negedge clk);
        checks++;
        if (ocnt != ob) begin fails++; $display("FAIL midrst_no_output got %0d want 0", ocnt - ob); end
        for (int i = 0; i < 64; i++) samp[0][i] = int'($urandom_range(0, 65535));
        rd_base = rdcnt;
        ob = ocnt;
        start_block();
        for (int i = 0; i < 300 && ocnt < ob + 32; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++;
        if (ocnt - ob != 32) begin
            fails++;
            $display("FAIL midrst_pair_count got %0d want 32", ocnt - ob);
        end else begin
            for (int j = 0; j < 32; j++) begin
                w  = (ob + j) % 1024;
                p  = j / 4;
                c  = j % 4;
                e0 = coef(0, p, u_first[c]);
                e1 = coef(0, p, u_second[c]);
                checks += 2;
                if (o_d0[w] != e0 || o_pg[w] != p) begin fails++; $display("FAIL midrst_d0 p=%0d c=%0d got %0d want %0d", p, c, o_d0[w], e0); end
                if (o_d1[w] != e1 || o_ct[w] != c) begin fails++; $display("FAIL midrst_d1 p=%0d c=%0d got %0d want %0d", p, c, o_d1[w], e1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_back_to_back();
        test_reset_midblock();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
